// File: rtl/id_decode_stage_pkg.sv
// id_decode_stage_pkg: immediate-format, opcode and control-flag types shared by the decode stage
package id_decode_stage_pkg;
    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_OP     = 7'b0110011,
        OP_FENCE  = 7'b0001111,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic uses_imm;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic is_branch;
        logic is_jump;
        logic illegal;
    } ctrl_t;
endpackage

// File: rtl/rv_opcode_decode.sv
// rv_opcode_decode: combinational opcode decode into immediate format and control flags
module rv_opcode_decode
    import id_decode_stage_pkg::*;
(
    input  logic [11:0] i_instr,
    output imm_sel_e    o_imm_sel,
    output ctrl_t       o_ctrl
);
    always_comb begin
        o_imm_sel = IMM_I;
        o_ctrl    = '0;
        case (i_instr[6:0])
            OP_LUI, OP_AUIPC: begin
                o_imm_sel        = IMM_U;
                o_ctrl.uses_imm  = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            OP_JAL: begin
                o_imm_sel        = IMM_J;
                o_ctrl.uses_imm  = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.is_jump   = 1'b1;
            end
            OP_JALR: begin
                o_ctrl.uses_imm  = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.is_jump   = 1'b1;
            end
            OP_BRANCH: begin
                o_imm_sel        = IMM_B;
                o_ctrl.uses_imm  = 1'b1;
                o_ctrl.is_branch = 1'b1;
            end
            OP_LOAD: begin
                o_ctrl.uses_imm  = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.mem_read  = 1'b1;
            end
            OP_STORE: begin
                o_imm_sel        = IMM_S;
                o_ctrl.uses_imm  = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            OP_IMM: begin
                o_ctrl.uses_imm  = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            OP_OP:                o_ctrl.reg_write = 1'b1;
            OP_FENCE, OP_SYSTEM:  o_ctrl = '0;
            default:              o_ctrl.illegal = 1'b1;
        endcase
        // writes to x0 are architecturally discarded
        if (i_instr[11:7] == 5'd0) o_ctrl.reg_write = 1'b0;
    end
endmodule

// File: rtl/id_decode_stage.sv
// id_decode_stage: IF/ID pipeline register with registered decode, stall hold and flush bubble
module id_decode_stage
    import id_decode_stage_pkg::*;
#(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_if_valid,
    input  logic [XLEN-1:0] i_if_pc,
    input  logic [31:0]     i_if_instr,
    output logic            o_id_valid,
    output logic [XLEN-1:0] o_id_pc,
    output logic [31:0]     o_id_instr,
    output imm_sel_e        o_id_imm_sel,
    output logic [4:0]      o_id_rs1,
    output logic [4:0]      o_id_rs2,
    output logic [4:0]      o_id_rd,
    output logic [2:0]      o_id_funct3,
    output logic [6:0]      o_id_funct7,
    output logic            o_id_uses_imm,
    output logic            o_id_reg_write,
    output logic            o_id_mem_read,
    output logic            o_id_mem_write,
    output logic            o_id_is_branch,
    output logic            o_id_is_jump,
    output logic            o_id_illegal
);
    imm_sel_e        w_imm_sel;
    ctrl_t           w_ctrl;
    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    imm_sel_e        r_imm_sel;
    ctrl_t           r_ctrl;

    rv_opcode_decode u_dec (
        .i_instr   (i_if_instr[11:0]),
        .o_imm_sel (w_imm_sel),
        .o_ctrl    (w_ctrl)
    );

    // an invalid fetch on a load edge becomes a bubble so no stale decode leaks downstream
    always_ff @(posedge clk) begin
        if (rst || i_flush || (!i_stall && !i_if_valid)) begin
            r_valid   <= 1'b0;
            r_pc      <= RESET_PC;
            r_instr   <= NOP_INSTR;
            r_imm_sel <= IMM_I;
            r_ctrl    <= '0;
        end else if (!i_stall) begin
            r_valid   <= 1'b1;
            r_pc      <= i_if_pc;
            r_instr   <= i_if_instr;
            r_imm_sel <= w_imm_sel;
            r_ctrl    <= w_ctrl;
        end
    end

    assign o_id_valid     = r_valid;
    assign o_id_pc        = r_pc;
    assign o_id_instr     = r_instr;
    assign o_id_imm_sel   = r_imm_sel;
    assign o_id_rs1       = r_instr[19:15];
    assign o_id_rs2       = r_instr[24:20];
    assign o_id_rd        = r_instr[11:7];
    assign o_id_funct3    = r_instr[14:12];
    assign o_id_funct7    = r_instr[31:25];
    assign o_id_uses_imm  = r_ctrl.uses_imm;
    assign o_id_reg_write = r_ctrl.reg_write;
    assign o_id_mem_read  = r_ctrl.mem_read;
    assign o_id_mem_write = r_ctrl.mem_write;
    assign o_id_is_branch = r_ctrl.is_branch;
    assign o_id_is_jump   = r_ctrl.is_jump;
    assign o_id_illegal   = r_ctrl.illegal;
endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage: directed and random checks of id_decode_stage against a behavioural model
module tb_id_decode_stage;
    import id_decode_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, stall, flush, if_valid;
    logic [31:0] if_pc, if_instr;
    logic        id_valid;
    logic [31:0] id_pc, id_instr;
    imm_sel_e    id_imm_sel;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic        id_uses_imm, id_reg_write, id_mem_read, id_mem_write;
    logic        id_is_branch, id_is_jump, id_illegal;

    int n_vec = 0;
    int n_err = 0;

    logic        m_valid;
    logic [31:0] m_pc, m_instr;

    id_decode_stage dut (
        .clk(clk), .rst(rst), .i_stall(stall), .i_flush(flush),
        .i_if_valid(if_valid), .i_if_pc(if_pc), .i_if_instr(if_instr),
        .o_id_valid(id_valid), .o_id_pc(id_pc), .o_id_instr(id_instr),
        .o_id_imm_sel(id_imm_sel), .o_id_rs1(id_rs1), .o_id_rs2(id_rs2),
        .o_id_rd(id_rd), .o_id_funct3(id_funct3), .o_id_funct7(id_funct7),
        .o_id_uses_imm(id_uses_imm), .o_id_reg_write(id_reg_write),
        .o_id_mem_read(id_mem_read), .o_id_mem_write(id_mem_write),
        .o_id_is_branch(id_is_branch), .o_id_is_jump(id_is_jump),
        .o_id_illegal(id_illegal)
    );

    always #5 clk = ~clk;

    // expected {imm_sel[2:0], uses_imm, reg_write, mem_read, mem_write, is_branch, is_jump, illegal}
    function automatic logic [9:0] exp_dec(input logic [31:0] ins, input logic valid);
        logic [9:0] e;
        if (!valid) return {3'(IMM_I), 7'b0};
        case (ins[6:0])
            7'b0110111, 7'b0010111: e = {3'(IMM_U), 7'b1100000};
            7'b1101111:             e = {3'(IMM_J), 7'b1100010};
            7'b1100111:             e = {3'(IMM_I), 7'b1100010};
            7'b1100011:             e = {3'(IMM_B), 7'b1000100};
            7'b0000011:             e = {3'(IMM_I), 7'b1110000};
            7'b0100011:             e = {3'(IMM_S), 7'b1001000};
            7'b0010011:             e = {3'(IMM_I), 7'b1100000};
            7'b0110011:             e = {3'(IMM_I), 7'b0100000};
            7'b0001111, 7'b1110011: e = {3'(IMM_I), 7'b0000000};
            default:                e = {3'(IMM_I), 7'b0000001};
        endcase
        if (ins[11:7] == 5'd0) e[5] = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] i, input imm_sel_e s);
        case (s)
            IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   return {i[31:12], 12'b0};
            IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return {{20{i[31]}}, i[31:20]};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        logic [9:0] e;
        e = exp_dec(m_instr, m_valid);
        chk("valid",     32'(id_valid), 32'(m_valid));
        chk("pc",        id_pc, m_pc);
        chk("instr",     id_instr, m_instr);
        chk("imm_sel",   32'(id_imm_sel), 32'(e[9:7]));
        chk("rs1",       32'(id_rs1), 32'(m_instr[19:15]));
        chk("rs2",       32'(id_rs2), 32'(m_instr[24:20]));
        chk("rd",        32'(id_rd), 32'(m_instr[11:7]));
        chk("funct3",    32'(id_funct3), 32'(m_instr[14:12]));
        chk("funct7",    32'(id_funct7), 32'(m_instr[31:25]));
        chk("flags",     32'({id_uses_imm, id_reg_write, id_mem_read, id_mem_write,
                              id_is_branch, id_is_jump, id_illegal}), 32'(e[6:0]));
    endtask

    task automatic step(input logic r, input logic f, input logic s, input logic v,
                        input logic [31:0] pc, input logic [31:0] ins);
        rst = r; flush = f; stall = s; if_valid = v; if_pc = pc; if_instr = ins;
        @(posedge clk);
        if (r || f || (!s && !v)) begin
            m_valid = 1'b0; m_pc = 32'h0; m_instr = 32'h0000_0013;
        end else if (!s) begin
            m_valid = 1'b1; m_pc = pc; m_instr = ins;
        end
        #1 check_all();
    endtask

    initial begin
        logic [6:0] ops [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                                 7'b0110011, 7'b0001111, 7'b1110011};
        m_valid = 1'bx; m_pc = 'x; m_instr = 'x;
        step(1, 0, 0, 1, 32'h44, 32'h0051_0093);
        step(1, 1, 1, 1, 32'h44, 32'h0051_0093);
        chk("rst_instr", id_instr, 32'h0000_0013);
        chk("rst_valid", 32'(id_valid), 32'd0);
        step(0, 0, 0, 1, 32'h100, 32'h0051_0093);
        chk("addi_sel", 32'(id_imm_sel), 32'(IMM_I));
        chk("addi_rd_rs1", {id_rd, id_rs1}, {5'd1, 5'd2});
        chk("addi_rw", {id_uses_imm, id_reg_write}, 2'b11);
        step(0, 0, 0, 1, 32'h104, 32'h0051_2423);
        chk("sw_imm", imm_of(id_instr, id_imm_sel), 32'd8);
        chk("sw_mw", 32'(id_mem_write), 32'd1);
        step(0, 0, 0, 1, 32'h108, 32'h0000_0463);
        chk("beq_imm", imm_of(id_instr, id_imm_sel), 32'd8);
        step(0, 0, 0, 1, 32'h10c, 32'h1234_50B7);
        chk("lui_imm", imm_of(id_instr, id_imm_sel), 32'h1234_5000);
        step(0, 0, 0, 1, 32'h110, 32'h0080_00EF);
        chk("jal_imm", imm_of(id_instr, id_imm_sel), 32'd8);
        chk("jal_jump", 32'(id_is_jump), 32'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 32'h200 + 32'(i), 32'h0051_0093);
        chk("stall_hold", id_pc, 32'h110);
        step(0, 0, 0, 1, 32'h300, 32'h0051_0093);
        chk("stall_release", id_pc, 32'h300);
        step(0, 1, 1, 1, 32'h304, 32'h0051_2423);
        chk("flush_stall", {31'(id_valid), 1'b0} | 32'(id_instr == 32'h13), 32'd1);
        step(0, 0, 0, 1, 32'h308, 32'h0051_2423);
        step(0, 0, 0, 0, 32'h30c, 32'h0051_2423);
        chk("invalid_bubble", 32'(id_valid), 32'd0);
        step(0, 0, 0, 1, 32'h310, 32'hFFFF_FFFF);
        chk("illegal", 32'(id_illegal), 32'd1);
        step(0, 0, 0, 1, 32'h314, 32'h0000_0033);
        chk("add_x0_rw", 32'(id_reg_write), 32'd0);
        step(0, 0, 1, 1, 32'h318, 32'h0051_0093);
        step(1, 0, 1, 1, 32'h31c, 32'h0051_0093);
        chk("rst_over_stall", 32'(id_valid), 32'd0);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(0, 9) < 8) ins[6:0] = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 4) == 0) ins[11:7] = 5'd0;
            step(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 6) != 0),
                 $urandom, ins);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
